// File: rtl/mlp_mac_pipe.sv
// Pipelined multiply-accumulate for MLP dot products, framed by first/last markers.
// Latency: MUL_STAGES+2 ce-cycles from the last term sampled to the out_valid pulse.
// No backpressure: ce=0 freezes every register, out_valid included; reset overrides ce.
module mlp_mac_pipe #(
   parameter logic [31:0] ID         = 32'd1,
   parameter int          din0_WIDTH = 9,
   parameter int          din1_WIDTH = 11,
   parameter int          dout_WIDTH = 32,
   parameter int          MUL_STAGES = 2,
   parameter int          SIGNED     = 0,
   parameter int          SATURATE   = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  in_valid,
   input  logic                  in_first,
   input  logic                  in_last,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  out_valid,
   output logic [dout_WIDTH-1:0] dout,
   output logic                  dout_ovf
);

   localparam int PW = din0_WIDTH + din1_WIDTH;
   localparam int DW = dout_WIDTH;

   // The accumulator must hold a full product, and there must be at least one product stage.
   if (MUL_STAGES < 1 || DW < PW) begin : g_bad_cfg
      $error("mlp_mac_pipe: need MUL_STAGES >= 1 and dout_WIDTH >= din0_WIDTH+din1_WIDTH");
   end

   // The instance tag has no functional effect; it only shows up as a named scope.
   if (ID == 32'd0) begin : g_untagged
   end else begin : g_tagged
   end

   // Input register stage
   logic [din0_WIDTH-1:0] a_q;
   logic [din1_WIDTH-1:0] b_q;
   logic                  in_v_q;
   logic                  in_f_q;
   logic                  in_l_q;

   // Product stages
   logic [PW-1:0]         a_ext;
   logic [PW-1:0]         b_ext;
   logic [PW-1:0]         prod;
   logic [PW-1:0]         p_q [MUL_STAGES];
   logic [MUL_STAGES-1:0] p_v;
   logic [MUL_STAGES-1:0] p_f;
   logic [MUL_STAGES-1:0] p_l;
   logic [PW-1:0]         p_tail;

   // Accumulator stage
   logic [DW-1:0] p_ext;
   logic [DW-1:0] acc_q;
   logic          ovf_q;
   logic [DW:0]   sum;
   logic          add_ovf;
   logic [DW-1:0] sat_val;
   logic [DW-1:0] acc_nxt;
   logic          ovf_nxt;

   // Register operands and framing bits; valid is cleared on reset so in-flight terms die.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_q    <= '0;
         b_q    <= '0;
         in_v_q <= 1'b0;
         in_f_q <= 1'b0;
         in_l_q <= 1'b0;
      end else if (ce) begin
         a_q    <= din0;
         b_q    <= din1;
         in_v_q <= in_valid;
         in_f_q <= in_first;
         in_l_q <= in_last;
      end
   end

   // Extend both operands to product width; the low PW bits of the product of the
   // extended operands are exactly the signed (or unsigned) product.
   always_comb begin
      a_ext                   = '0;
      b_ext                   = '0;
      a_ext[din0_WIDTH-1:0]   = a_q;
      b_ext[din1_WIDTH-1:0]   = b_q;
      if (SIGNED != 0) begin
         a_ext[PW-1:din0_WIDTH] = {din1_WIDTH{a_q[din0_WIDTH-1]}};
         b_ext[PW-1:din1_WIDTH] = {din0_WIDTH{b_q[din1_WIDTH-1]}};
      end
      prod = a_ext * b_ext;
   end

   // Product shift register: stage 0 captures the multiplier, later stages retime it.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < MUL_STAGES; i++) begin
            p_q[i] <= '0;
         end
         p_v <= '0;
         p_f <= '0;
         p_l <= '0;
      end else if (ce) begin
         p_q[0] <= prod;
         p_v[0] <= in_v_q;
         p_f[0] <= in_f_q;
         p_l[0] <= in_l_q;
         for (int i = 1; i < MUL_STAGES; i++) begin
            p_q[i] <= p_q[i-1];
            p_v[i] <= p_v[i-1];
            p_f[i] <= p_f[i-1];
            p_l[i] <= p_l[i-1];
         end
      end
   end

   assign p_tail = p_q[MUL_STAGES-1];

   // Widen the product to accumulator width, sign-filling only in signed mode.
   always_comb begin
      p_ext = '0;
      if (SIGNED != 0 && p_tail[PW-1]) begin
         p_ext = '1;
      end
      p_ext[PW-1:0] = p_tail;
   end

   // Next accumulator value, overflow detection and optional clamping.
   always_comb begin
      sum     = {1'b0, acc_q} + {1'b0, p_ext};
      add_ovf = 1'b0;
      sat_val = '1;
      if (SIGNED != 0) begin
         // Same-sign addends whose sum flips sign; clamp toward the addends' sign.
         add_ovf = (acc_q[DW-1] == p_ext[DW-1]) && (sum[DW-1] != acc_q[DW-1]);
         sat_val = acc_q[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      end else begin
         add_ovf = sum[DW];
      end

      if (p_f[MUL_STAGES-1]) begin
         // A first term restarts the vector and cannot overflow.
         acc_nxt = p_ext;
         ovf_nxt = 1'b0;
      end else begin
         acc_nxt = (SATURATE != 0 && add_ovf) ? sat_val : sum[DW-1:0];
         ovf_nxt = ovf_q | add_ovf;
      end
   end

   // Accumulate valid products; publish on the last term as a one-ce-cycle pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q     <= '0;
         ovf_q     <= 1'b0;
         out_valid <= 1'b0;
         dout      <= '0;
         dout_ovf  <= 1'b0;
      end else if (ce) begin
         out_valid <= 1'b0;
         if (p_v[MUL_STAGES-1]) begin
            acc_q <= acc_nxt;
            ovf_q <= ovf_nxt;
            if (p_l[MUL_STAGES-1]) begin
               dout      <= acc_nxt;
               dout_ovf  <= ovf_nxt;
               out_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mlp_mac_pipe.sv
// Directed bench for mlp_mac_pipe: four configurations share one stimulus stream,
// a vector table covers framing and arithmetic, hand sequences cover ce freeze,
// back-to-back results and reset mid-vector.
module tb_mlp_mac_pipe;

   logic        clk;
   logic        reset;
   logic        ce;
   logic        in_valid;
   logic        in_first;
   logic        in_last;
   logic [8:0]  din0;
   logic [10:0] din1;

   logic        v0, v1, v2, v3;
   logic [31:0] d0, d1;
   logic [19:0] d2, d3;
   logic        o0, o1, o2, o3;

   // Selected-DUT view used by the checks
   logic [1:0]  sel;
   logic        m_vld;
   logic [31:0] m_dout;
   logic        m_ovf;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [2:0]        n;
      logic [3:0][8:0]   a;
      logic [3:0][10:0]  b;
      logic [3:0]        v;
      logic [3:0]        f;
      logic [3:0]        l;
      logic [1:0]        sel;
      logic [31:0]       exp;
      logic              ovf;
   } vec_t;

   vec_t tbl [7];

   mlp_mac_pipe #(.ID(32'd1)) u_dut (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
      .in_last(in_last), .din0(din0), .din1(din1),
      .out_valid(v0), .dout(d0), .dout_ovf(o0));

   mlp_mac_pipe #(.ID(32'd2), .SIGNED(1)) u_sgn (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
      .in_last(in_last), .din0(din0), .din1(din1),
      .out_valid(v1), .dout(d1), .dout_ovf(o1));

   mlp_mac_pipe #(.ID(32'd3), .dout_WIDTH(20), .SATURATE(1)) u_sat (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
      .in_last(in_last), .din0(din0), .din1(din1),
      .out_valid(v2), .dout(d2), .dout_ovf(o2));

   mlp_mac_pipe #(.ID(32'd4), .dout_WIDTH(20), .SATURATE(0)) u_wrap (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
      .in_last(in_last), .din0(din0), .din1(din1),
      .out_valid(v3), .dout(d3), .dout_ovf(o3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Route the configuration under test to the common check signals.
   always_comb begin
      m_vld  = v0;
      m_dout = d0;
      m_ovf  = o0;
      case (sel)
         2'd1: begin m_vld = v1; m_dout = d1;           m_ovf = o1; end
         2'd2: begin m_vld = v2; m_dout = {12'h0, d2};  m_ovf = o2; end
         2'd3: begin m_vld = v3; m_dout = {12'h0, d3};  m_ovf = o3; end
         default: ;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
      end
   endtask

   task automatic drive(input logic [8:0] a, input logic [10:0] b,
                        input logic v, input logic f, input logic l);
      @(negedge clk);
      din0     = a;
      din1     = b;
      in_valid = v;
      in_first = f;
      in_last  = l;
   endtask

   // Apply one framed vector, then watch 8 edges after the last term is sampled.
   task automatic run_vec(input vec_t t, input string tag);
      int          first_k;
      int          pulses;
      logic [31:0] cap_d;
      logic        cap_o;
      first_k = 0;
      pulses  = 0;
      cap_d   = 32'h0;
      cap_o   = 1'b0;
      sel     = t.sel;
      for (int i = 0; i < int'(t.n); i++) begin
         drive(t.a[i], t.b[i], t.v[i], t.f[i], t.l[i]);
      end
      drive(9'd0, 11'd0, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         #1;
         if (m_vld) begin
            pulses++;
            if (first_k == 0) begin
               first_k = k;
               cap_d   = m_dout;
               cap_o   = m_ovf;
            end
         end
      end
      check({tag, " latency"}, 32'(first_k), 32'd3);
      check({tag, " pulses"},  32'(pulses),  32'd1);
      check({tag, " dout"},    cap_d,        t.exp);
      check({tag, " ovf"},     {31'h0, cap_o}, {31'h0, t.ovf});
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish, %0d vectors applied", n_vec);
      $fatal(1);
   end

   initial begin
      int          first_k;
      int          pulses;
      logic [31:0] cap_d;
      logic [31:0] b2b_d [1:4];
      logic        b2b_v [1:4];

      // term order inside each field is [3] [2] [1] [0]
      tbl[0] = '{n:3'd1, a:{9'd0, 9'd0, 9'd0, 9'd2}, b:{11'd0, 11'd0, 11'd0, 11'd3},
                 v:4'b0001, f:4'b0000, l:4'b0001, sel:2'd0, exp:32'd6, ovf:1'b0};
      tbl[1] = '{n:3'd1, a:{9'd0, 9'd0, 9'd0, 9'd511}, b:{11'd0, 11'd0, 11'd0, 11'd2047},
                 v:4'b0001, f:4'b0001, l:4'b0001, sel:2'd0, exp:32'd1046017, ovf:1'b0};
      tbl[2] = '{n:3'd4, a:{9'd7, 9'd0, 9'd5, 9'd3}, b:{11'd8, 11'd0, 11'd6, 11'd4},
                 v:4'b1011, f:4'b0001, l:4'b1000, sel:2'd0, exp:32'd98, ovf:1'b0};
      tbl[3] = '{n:3'd2, a:{9'd0, 9'd0, 9'h0FF, 9'h100}, b:{11'd0, 11'd0, 11'h400, 11'h3FF},
                 v:4'b0011, f:4'b0001, l:4'b0010, sel:2'd1, exp:32'hFFF8_0500, ovf:1'b0};
      tbl[4] = '{n:3'd2, a:{9'd0, 9'd0, 9'd511, 9'd511}, b:{11'd0, 11'd0, 11'd2047, 11'd2047},
                 v:4'b0011, f:4'b0001, l:4'b0010, sel:2'd2, exp:32'd1048575, ovf:1'b1};
      tbl[5] = '{n:3'd2, a:{9'd0, 9'd0, 9'd511, 9'd511}, b:{11'd0, 11'd0, 11'd2047, 11'd2047},
                 v:4'b0011, f:4'b0001, l:4'b0010, sel:2'd3, exp:32'd1043458, ovf:1'b1};
      tbl[6] = '{n:3'd3, a:{9'd0, 9'd3, 9'd2, 9'd1}, b:{11'd0, 11'd3, 11'd2, 11'd1},
                 v:4'b0111, f:4'b0101, l:4'b0100, sel:2'd0, exp:32'd9, ovf:1'b0};

      sel      = 2'd0;
      reset    = 1'b1;
      ce       = 1'b0;
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
      din0     = 9'd0;
      din1     = 11'd0;

      // Reset with ce low must still clear the outputs.
      repeat (3) @(negedge clk);
      check("reset out_valid", {31'h0, v0}, 32'd0);
      check("reset dout",      d0,          32'd0);
      check("reset dout_ovf",  {31'h0, o0}, 32'd0);
      check("reset sgn dout",  d1,          32'd0);
      check("reset sat flags", {30'h0, v2, o2}, 32'd0);
      reset = 1'b0;
      ce    = 1'b1;

      // Table: entry 0 relies on the post-reset accumulator being zero.
      for (int i = 0; i < 7; i++) begin
         run_vec(tbl[i], $sformatf("vec%0d", i));
      end

      // ce low for three edges after the last term: pulse slips by three edges.
      sel     = 2'd0;
      first_k = 0;
      cap_d   = 32'h0;
      drive(9'd3, 11'd4, 1'b1, 1'b1, 1'b0);
      drive(9'd5, 11'd6, 1'b1, 1'b0, 1'b0);
      drive(9'd0, 11'd0, 1'b0, 1'b0, 1'b0);
      drive(9'd7, 11'd8, 1'b1, 1'b0, 1'b1);
      drive(9'd0, 11'd0, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk);
         #1;
         if (m_vld && first_k == 0) begin
            first_k = k;
            cap_d   = m_dout;
         end
         if (k == 1) begin
            // garbage term presented while frozen must not be sampled
            @(negedge clk);
            ce = 1'b0;
            din0 = 9'd100; din1 = 11'd100;
            in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1;
         end
         if (k == 4) begin
            @(negedge clk);
            ce = 1'b1;
            in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
         end
      end
      check("ce freeze latency", 32'(first_k), 32'd6);
      check("ce freeze dout",    cap_d,        32'd98);
      @(negedge clk);
      ce = 1'b0;
      @(posedge clk);
      #1;
      check("ce holds out_valid", {31'h0, m_vld}, 32'd1);
      @(negedge clk);
      ce = 1'b1;
      @(posedge clk);
      #1;
      check("pulse ends", {31'h0, m_vld}, 32'd0);
      repeat (6) @(posedge clk);

      // Back-to-back single-term vectors give results on consecutive cycles.
      drive(9'd2, 11'd3, 1'b1, 1'b1, 1'b1);
      drive(9'd4, 11'd5, 1'b1, 1'b1, 1'b1);
      drive(9'd0, 11'd0, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         #1;
         b2b_v[k] = m_vld;
         b2b_d[k] = m_dout;
      end
      check("b2b k2 valid", {31'h0, b2b_v[2]}, 32'd1);
      check("b2b k2 dout",  b2b_d[2],          32'd6);
      check("b2b k3 valid", {31'h0, b2b_v[3]}, 32'd1);
      check("b2b k3 dout",  b2b_d[3],          32'd20);
      check("b2b k4 valid", {31'h0, b2b_v[4]}, 32'd0);
      repeat (4) @(posedge clk);

      // Reset after term 2 of a vector: nothing comes out, accumulator restarts at 0.
      drive(9'd3, 11'd4, 1'b1, 1'b1, 1'b0);
      drive(9'd5, 11'd6, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
      @(negedge clk);
      reset  = 1'b0;
      pulses = 0;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk);
         #1;
         if (m_vld) pulses++;
      end
      check("reset drops vector", 32'(pulses), 32'd0);
      run_vec(tbl[0], "post-reset no-first");
      run_vec(tbl[1], "post-reset single");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
